// File: rtl/proc_run_ctrl.sv
// Run controller for the single-cycle core.
// It holds the core in reset, runs it from a start PC, and stops at a stop address or when the watchdog limit is reached.
module proc_run_ctrl #(
  parameter int AW         = 64,
  parameter int RST_CYCLES = 2,
  parameter int WD_W       = 16
) (
  input  logic            CLK,
  input  logic            resetl,
  input  logic            start,
  input  logic            abort,
  input  logic [AW-1:0]   start_pc,
  input  logic [AW-1:0]   stop_pc,
  input  logic [WD_W-1:0] max_cycles,
  input  logic [AW-1:0]   currentpc,
  input  logic [AW-1:0]   memtoreg_out,
  output logic            core_resetl,
  output logic [AW-1:0]   core_startpc,
  output logic            core_en,
  output logic            busy,
  output logic            done,
  output logic            timeout,
  output logic [AW-1:0]   result,
  output logic [WD_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } state_e;

  // Run parameters captured at start; they stay fixed until the next start.
  typedef struct packed {
    logic [AW-1:0]   start_pc;
    logic [AW-1:0]   stop_pc;
    logic [WD_W-1:0] max_cycles;
  } run_cfg_t;

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LOAD = RCW'(RST_CYCLES - 1);

  state_e          state_q, state_d;
  run_cfg_t        cfg_q, cfg_d;
  logic [RCW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [WD_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   result_q, result_d;

  logic            can_start;
  logic            stop_hit;
  logic            wd_hit;
  logic            rst_done;
  logic [WD_W:0]   cnt_inc;

  assign can_start = start && (state_q inside {ST_IDLE, ST_DONE, ST_TIMEOUT});
  assign stop_hit  = (currentpc >= cfg_q.stop_pc);
  assign rst_done  = (rst_cnt_q == '0);
  // One extra bit so the saturated count can never alias a small limit.
  assign cnt_inc   = {1'b0, cnt_q} + {{WD_W{1'b0}}, 1'b1};
  assign wd_hit    = (cfg_q.max_cycles != '0) && (cnt_inc == {1'b0, cfg_q.max_cycles});

  // State register
  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first, so no path leaves state_d unassigned and no latch is inferred.
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_TIMEOUT: begin
          if (start) state_d = ST_RESET;
        end
        ST_RESET: begin
          if (rst_done) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (stop_hit)    state_d = ST_DONE;
          else if (wd_hit) state_d = ST_TIMEOUT;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath next-state: run config, reset counter, cycle counter, result
  always_comb begin
    cfg_d     = cfg_q;
    rst_cnt_d = rst_cnt_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    if (!abort) begin
      if (can_start) begin
        cfg_d.start_pc   = start_pc;
        cfg_d.stop_pc    = stop_pc;
        cfg_d.max_cycles = max_cycles;
        rst_cnt_d        = RST_LOAD;
        cnt_d            = '0;
        result_d         = '0;
      end else if (state_q == ST_RESET) begin
        if (!rst_done) rst_cnt_d = rst_cnt_q - RCW'(1);
      end else if (state_q == ST_RUN) begin
        if (!(&cnt_q)) cnt_d = cnt_q + WD_W'(1);
        if (stop_hit)  result_d = memtoreg_out;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      cfg_q     <= '0;
      rst_cnt_q <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      cfg_q     <= cfg_d;
      rst_cnt_q <= rst_cnt_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  // Output decode: control outputs depend on state only.
  always_comb begin
    core_resetl = 1'b0;
    core_en     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    timeout     = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_RESET: begin
        busy = 1'b1;
      end
      ST_RUN: begin
        core_resetl = 1'b1;
        core_en     = 1'b1;
        busy        = 1'b1;
      end
      ST_DONE: begin
        core_resetl = 1'b1;
        done        = 1'b1;
      end
      ST_TIMEOUT: begin
        core_resetl = 1'b1;
        timeout     = 1'b1;
      end
      default: ;
    endcase
  end

  assign core_startpc = cfg_q.start_pc;
  assign result       = result_q;
  assign cycle_count  = cnt_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl. A small core model advances the PC by 4 on each enabled cycle.
// The bench drives inputs and samples outputs on the falling edge.
module tb_proc_run_ctrl;

  localparam int AW   = 64;
  localparam int WD_W = 16;

  logic            CLK;
  logic            resetl;
  logic            start;
  logic            abort;
  logic [AW-1:0]   start_pc;
  logic [AW-1:0]   stop_pc;
  logic [WD_W-1:0] max_cycles;
  logic [AW-1:0]   currentpc;
  logic [AW-1:0]   memtoreg_out;
  logic            core_resetl;
  logic [AW-1:0]   core_startpc;
  logic            core_en;
  logic            busy;
  logic            done;
  logic            timeout;
  logic [AW-1:0]   result;
  logic [WD_W-1:0] cycle_count;

  logic [AW-1:0]   wb_pc;
  logic [AW-1:0]   wb_val;
  logic [4:0]      status;

  int n_checks;
  int n_fail;

  // Expected status words {core_resetl, core_en, busy, done, timeout}
  localparam logic [4:0] S_IDLE    = 5'b00000;
  localparam logic [4:0] S_RESET   = 5'b00100;
  localparam logic [4:0] S_RUN     = 5'b11100;
  localparam logic [4:0] S_DONE    = 5'b10010;
  localparam logic [4:0] S_TIMEOUT = 5'b10001;

  proc_run_ctrl #(.AW(AW), .RST_CYCLES(2), .WD_W(WD_W)) dut (
    .CLK          (CLK),
    .resetl       (resetl),
    .start        (start),
    .abort        (abort),
    .start_pc     (start_pc),
    .stop_pc      (stop_pc),
    .max_cycles   (max_cycles),
    .currentpc    (currentpc),
    .memtoreg_out (memtoreg_out),
    .core_resetl  (core_resetl),
    .core_startpc (core_startpc),
    .core_en      (core_en),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .result       (result),
    .cycle_count  (cycle_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Core model: it loads the start PC while held in reset and steps by 4 while enabled.
  always @(posedge CLK) begin
    if (!core_resetl)  currentpc <= core_startpc;
    else if (core_en)  currentpc <= currentpc + 64'd4;
  end

  assign memtoreg_out = (currentpc == wb_pc) ? wb_val : ~currentpc;
  assign status       = {core_resetl, core_en, busy, done, timeout};

  task automatic do_start(input logic [AW-1:0] spc, input logic [AW-1:0] epc,
                          input logic [WD_W-1:0] mx);
    @(negedge CLK);
    start_pc   = spc;
    stop_pc    = epc;
    max_cycles = mx;
    start      = 1'b1;
    @(negedge CLK);
    start      = 1'b0;
  endtask

  // Step through falling edges until done or timeout, counting the cycles with core_en high.
  task automatic wait_end(input int budget, output int run_cycles, output bit ok);
    run_cycles = 0;
    ok         = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done || timeout) begin
        ok = 1'b1;
        break;
      end
      if (core_en) run_cycles++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    resetl     = 1'b0;
    start      = 1'b1;
    abort      = 1'b0;
    start_pc   = 64'h1234;
    stop_pc    = 64'h0;
    max_cycles = 16'd3;
    wb_pc      = '1;
    wb_val     = '0;
    @(negedge CLK);
    @(negedge CLK);
    n_checks++;
    if (status !== S_IDLE) begin
      n_fail++; $display("FAIL reset_status: got %b expected %b", status, S_IDLE);
    end
    n_checks++;
    if ({result, cycle_count, core_startpc} !== '0) begin
      n_fail++; $display("FAIL reset_regs: result=%h count=%h startpc=%h expected all 0",
                         result, cycle_count, core_startpc);
    end
    start  = 1'b0;
    resetl = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (status !== S_IDLE) begin
      n_fail++; $display("FAIL reset_release_idle: got %b expected %b", status, S_IDLE);
    end
  endtask

  task automatic test_normal_run();
    int rc;
    bit ok;
    wb_pc  = 64'h30;
    wb_val = 64'hF;
    do_start(64'h0, 64'h30, 16'hFF);
    n_checks++;
    if (status !== S_RESET || core_startpc !== 64'h0 || cycle_count !== 16'd0) begin
      n_fail++; $display("FAIL run_start: status=%b startpc=%h count=%0d expected %b 0 0",
                         status, core_startpc, cycle_count, S_RESET);
    end
    // These changes must have no effect on the run already in progress.
    start_pc   = 64'h100;
    stop_pc    = 64'h8;
    max_cycles = 16'd1;
    @(negedge CLK);
    n_checks++;
    if (status !== S_RESET) begin
      n_fail++; $display("FAIL run_reset_len2: got %b expected %b", status, S_RESET);
    end
    @(negedge CLK);
    n_checks++;
    if (status !== S_RUN || currentpc !== 64'h0) begin
      n_fail++; $display("FAIL run_enter: status=%b pc=%h expected %b pc 0", status, currentpc, S_RUN);
    end
    wait_end(200, rc, ok);
    n_checks++;
    if (!ok || rc != 13) begin
      n_fail++; $display("FAIL run_cycles: ended=%0d run cycles=%0d expected 1 13", ok, rc);
    end
    n_checks++;
    if (status !== S_DONE || result !== 64'hF || cycle_count !== 16'd13 || core_startpc !== 64'h0) begin
      n_fail++; $display("FAIL run_done: status=%b result=%h count=%0d startpc=%h expected %b f 13 0",
                         status, result, cycle_count, core_startpc, S_DONE);
    end
  endtask

  task automatic test_rerun();
    int rc;
    bit ok;
    wb_pc  = 64'h54;
    wb_val = 64'h123456789abcdef0;
    do_start(64'h30, 64'h54, 16'hFF);
    n_checks++;
    if (status !== S_RESET || core_startpc !== 64'h30 || cycle_count !== 16'd0 || result !== 64'h0) begin
      n_fail++; $display("FAIL rerun_start: status=%b startpc=%h count=%0d result=%h expected %b 30 0 0",
                         status, core_startpc, cycle_count, result, S_RESET);
    end
    wait_end(200, rc, ok);
    n_checks++;
    if (!ok || rc != 10 || status !== S_DONE) begin
      n_fail++; $display("FAIL rerun_end: ended=%0d cycles=%0d status=%b expected 1 10 %b",
                         ok, rc, status, S_DONE);
    end
    n_checks++;
    if (result !== 64'h123456789abcdef0 || cycle_count !== 16'd10) begin
      n_fail++; $display("FAIL rerun_result: result=%h count=%0d expected 123456789abcdef0 10",
                         result, cycle_count);
    end
  endtask

  task automatic test_watchdog();
    int rc;
    bit ok;
    wb_pc  = 64'h1000;
    wb_val = 64'h55;
    do_start(64'h0, 64'h1000, 16'd5);
    n_checks++;
    if (result !== 64'h0) begin
      n_fail++; $display("FAIL wd_result_clear: got %h expected 0", result);
    end
    wait_end(200, rc, ok);
    n_checks++;
    if (!ok || rc != 5) begin
      n_fail++; $display("FAIL wd_cycles: ended=%0d run cycles=%0d expected 1 5", ok, rc);
    end
    n_checks++;
    if (status !== S_TIMEOUT || cycle_count !== 16'd5 || result !== 64'h0) begin
      n_fail++; $display("FAIL wd_timeout: status=%b count=%0d result=%h expected %b 5 0",
                         status, cycle_count, result, S_TIMEOUT);
    end
  endtask

  task automatic test_tie();
    int rc;
    bit ok;
    wb_pc  = 64'h8;
    wb_val = 64'hABCD;
    do_start(64'h0, 64'h8, 16'd3);
    wait_end(200, rc, ok);
    n_checks++;
    if (!ok || rc != 3) begin
      n_fail++; $display("FAIL tie_cycles: ended=%0d run cycles=%0d expected 1 3", ok, rc);
    end
    n_checks++;
    if (status !== S_DONE || result !== 64'hABCD || cycle_count !== 16'd3) begin
      n_fail++; $display("FAIL tie_done: status=%b result=%h count=%0d expected %b abcd 3",
                         status, result, cycle_count, S_DONE);
    end
  endtask

  task automatic test_abort_done();
    @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    n_checks++;
    if (status !== S_IDLE || result !== 64'hABCD) begin
      n_fail++; $display("FAIL abort_done: status=%b result=%h expected %b abcd", status, result, S_IDLE);
    end
  endtask

  task automatic test_abort_mid_run();
    do_start(64'h0, 64'h1000, 16'd0);
    // A start request while busy must be ignored.
    start_pc = 64'h777;
    start    = 1'b1;
    @(negedge CLK);
    start    = 1'b0;
    n_checks++;
    if (status !== S_RESET || core_startpc !== 64'h0) begin
      n_fail++; $display("FAIL busy_start_ignored: status=%b startpc=%h expected %b 0",
                         status, core_startpc, S_RESET);
    end
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    n_checks++;
    if (status !== S_RUN || cycle_count !== 16'd2) begin
      n_fail++; $display("FAIL abort_pre: status=%b count=%0d expected %b 2", status, cycle_count, S_RUN);
    end
    abort = 1'b1;
    start = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    start = 1'b0;
    n_checks++;
    if (status !== S_IDLE || result !== 64'h0) begin
      n_fail++; $display("FAIL abort_run: status=%b result=%h expected %b 0", status, result, S_IDLE);
    end
    @(negedge CLK);
    n_checks++;
    if (status !== S_IDLE) begin
      n_fail++; $display("FAIL abort_stays_idle: got %b expected %b", status, S_IDLE);
    end
  endtask

  task automatic test_wd_disabled();
    do_start(64'h0, 64'h1000, 16'd0);
    @(negedge CLK);
    @(negedge CLK);
    repeat (20) @(negedge CLK);
    n_checks++;
    if (status !== S_RUN || cycle_count !== 16'd20) begin
      n_fail++; $display("FAIL wd_disabled: status=%b count=%0d expected %b 20", status, cycle_count, S_RUN);
    end
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_normal_run();
    test_rerun();
    test_watchdog();
    test_tie();
    test_abort_done();
    test_abort_mid_run();
    test_wd_disabled();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
